// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, NOP encoding,
// default reset PC and the layout of one buffered fetch entry.
package if_fetch_unit_pkg;

  localparam int InstAddrWidth = 32;
  localparam int InstDataWidth = 32;

  localparam logic [InstDataWidth-1:0] NopInst        = 32'h0000_0000;
  localparam logic [InstAddrWidth-1:0] DefaultResetPc = 32'h0000_0000;

  // One FIFO entry as handed to decode; pc_plus4 sits in the upper bits.
  typedef struct packed {
    logic [InstAddrWidth-1:0] pc_plus4;
    logic [InstDataWidth-1:0] inst;
  } fetch_entry_t;

  localparam int FetchEntryWidth = $bits(fetch_entry_t);

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Small register FIFO holding returned instruction words; the head is read
// combinationally and clear takes priority over push and pop.
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = FetchEntryWidth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [WIDTH-1:0]           o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = i_push & ~i_clear;
  assign w_do_pop  = i_pop & ~i_clear & (r_count != '0);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH-1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_do_push && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order memory requests and
// presents buffered {pc_plus4, inst} to decode; redirects flush and discard.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = InstAddrWidth,
  parameter int                DATA_W   = InstDataWidth,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefaultResetPc),
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_stall,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc_plus4,
  output logic [DATA_W-1:0] id_inst
);

  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int SUM_W   = CNT_W + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_discard;

  logic [CNT_W-1:0]   w_fifo_count;
  logic [ENTRY_W-1:0] w_fifo_head;
  logic [ENTRY_W-1:0] w_fifo_wdata;
  logic [SUM_W-1:0]   w_inflight;
  logic [ADDR_W-1:0]  w_redirect_target;
  logic               w_req;
  logic               w_fire;
  logic               w_drop;
  logic               w_push;
  logic               w_valid;
  logic               w_pop;

  assign w_redirect_target = redirect_pc & ~ADDR_W'(3);

  // Capping requested-but-unbuffered plus buffered words at DEPTH means
  // every response always has a free FIFO slot, so no backpressure is needed.
  assign w_inflight = SUM_W'(r_outstanding) + SUM_W'(w_fifo_count);
  assign w_req      = rst & ~redirect_valid & (w_inflight < SUM_W'(DEPTH));
  assign w_fire     = w_req & imem_ready;

  assign w_drop  = (r_discard != '0);
  assign w_push  = imem_rvalid & ~w_drop & ~redirect_valid;
  assign w_valid = (w_fifo_count != '0);
  assign w_pop   = w_valid & ~id_stall;

  assign w_fifo_wdata = {r_resp_pc + ADDR_W'(4), imem_rdata};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc      <= w_redirect_target;
      r_resp_pc <= w_redirect_target;
    end else begin
      if (w_fire) begin
        r_pc <= r_pc + ADDR_W'(4);
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_outstanding <= '0;
    end else begin
      unique case ({w_fire, imem_rvalid})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // On redirect every request still unanswered after this cycle is stale.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_discard <= '0;
    end else if (redirect_valid) begin
      r_discard <= r_outstanding - CNT_W'(imem_rvalid);
    end else if (imem_rvalid && w_drop) begin
      r_discard <= r_discard - CNT_W'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (redirect_valid),
    .i_wdata (w_fifo_wdata),
    .o_count (w_fifo_count),
    .o_head  (w_fifo_head)
  );

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign id_valid    = w_valid;
  assign id_pc_plus4 = w_valid ? w_fifo_head[ENTRY_W-1:DATA_W] : '0;
  assign id_inst     = w_valid ? w_fifo_head[DATA_W-1:0] : DATA_W'(NopInst);

  a_resp_expected: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rvalid && (r_outstanding == '0)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_if_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall, id_valid;
  logic [31:0] id_pc_plus4, id_inst;

  logic        req2, rvalid2, valid2;
  logic [31:0] addr2, rdata2, pc42, inst2;

  always #5 clk = ~clk;

  if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_stall(id_stall), .id_valid(id_valid), .id_pc_plus4(id_pc_plus4), .id_inst(id_inst)
  );

  if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(req2), .imem_addr(addr2), .imem_ready(1'b1),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_stall(1'b0), .id_valid(valid2), .id_pc_plus4(pc42), .id_inst(inst2)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Memory model for the main instance: fixed latency, in order, addr^A5A5_0000.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    cyc = 0;
  int    lat = 1;

  always @(negedge clk) begin
    if (!rst) mq.delete();
    else if (imem_req && imem_ready) mq.push_back('{imem_addr, cyc + lat});
  end

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mq[0].addr ^ 32'hA5A5_0000;
        void'(mq.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  // Reference model: pending requests (with a kill flag set by redirects)
  // and the queue of words decode should see, in order.
  typedef struct { logic [31:0] addr; bit kill; } pend_t;
  typedef struct { logic [31:0] pc4; logic [31:0] inst; } ent_t;
  pend_t       m_pend[$];
  ent_t        m_fifo[$];
  logic [31:0] m_pc;
  bit          rst_d = 1'b1;

  always @(negedge clk) begin : cmp_proc
    pend_t p;
    bit    exp_req, exp_valid;
    if (!rst) begin
      if (!rst_d) begin
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_pc4", id_pc_plus4, 32'h0);
        chk("rst_inst", id_inst, 32'h0);
      end
      m_pend.delete();
      m_fifo.delete();
      m_pc = 32'h0;
    end else begin
      exp_req   = !redirect_valid && (m_pend.size() + m_fifo.size() < DEPTH);
      exp_valid = m_fifo.size() > 0;
      chk("m_req", {31'b0, imem_req}, {31'b0, exp_req});
      chk("m_addr", imem_addr, m_pc);
      chk("m_valid", {31'b0, id_valid}, {31'b0, exp_valid});
      chk("m_pc4", id_pc_plus4, exp_valid ? m_fifo[0].pc4 : 32'h0);
      chk("m_inst", id_inst, exp_valid ? m_fifo[0].inst : 32'h0);
      if (!redirect_valid && exp_valid && !id_stall) void'(m_fifo.pop_front());
      if (imem_rvalid) begin
        if (m_pend.size() == 0) begin
          chk("m_spurious_resp", 32'd1, 32'd0);
        end else begin
          p = m_pend.pop_front();
          if (!p.kill && !redirect_valid) m_fifo.push_back('{p.addr + 32'd4, imem_rdata});
        end
      end
      if (redirect_valid) begin
        m_fifo.delete();
        foreach (m_pend[i]) m_pend[i].kill = 1'b1;
        m_pc = redirect_pc & ~32'd3;
      end else if (exp_req && imem_ready) begin
        m_pend.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    rst_d = rst;
  end

  // Wrap-around instance: always-ready 1-cycle memory returning the address.
  logic [31:0] q_addr2[$];
  logic [31:0] q_pc2[$];
  logic        pend2 = 1'b0;
  logic [31:0] pend_addr2 = 32'h0;
  logic [31:0] exp_a2 [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
  logic [31:0] exp_p2 [3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

  always @(negedge clk) begin
    if (!rst) begin
      q_addr2.delete();
      q_pc2.delete();
      pend2 = 1'b0;
    end else begin
      if (req2) q_addr2.push_back(addr2);
      if (valid2) q_pc2.push_back(pc42);
      pend2      = req2;
      pend_addr2 = addr2;
    end
  end

  initial begin
    rvalid2 = 1'b0;
    rdata2  = 32'h0;
    forever begin
      @(posedge clk); #1;
      rvalid2 = pend2;
      rdata2  = pend_addr2;
    end
  end

  task automatic cyc_in();
    @(posedge clk); #1;
  endtask

  task automatic restart(input int l, input logic rdy, input logic stl);
    cyc_in();
    rst = 1'b0; redirect_valid = 1'b0; id_stall = 1'b0; imem_ready = 1'b1;
    repeat (2) cyc_in();
    lat = l; imem_ready = rdy; id_stall = stl; rst = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int maxc);
    int k = 0;
    @(negedge clk);
    while (!id_valid && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'b0, id_valid}, 32'd1);
  endtask

  task automatic wait_req(input string name, input int maxc);
    int k = 0;
    @(negedge clk);
    while (!imem_req && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'b0, imem_req}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; imem_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'h0; id_stall = 1'b0;

    // Streaming from reset, no stall.
    restart(1, 1'b1, 1'b0);
    wait_valid("t1_wait", 20);
    chk("t1_pc4_a", id_pc_plus4, 32'h0000_0004);
    chk("t1_inst_a", id_inst, 32'hA5A5_0000);
    @(negedge clk);
    chk("t1_pc4_b", id_pc_plus4, 32'h0000_0008);
    chk("t1_inst_b", id_inst, 32'hA5A5_0004);

    // Decode stalled for the first 5 cycles after reset.
    restart(1, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t2_req_low", {31'b0, imem_req}, 32'd0);
    chk("t2_valid", {31'b0, id_valid}, 32'd1);
    chk("t2_head_pc4", id_pc_plus4, 32'h0000_0004);
    chk("t2_head_inst", id_inst, 32'hA5A5_0000);
    cyc_in();
    id_stall = 1'b0;
    @(negedge clk);
    chk("t2_rel_pc4_a", id_pc_plus4, 32'h0000_0004);
    @(negedge clk);
    chk("t2_rel_pc4_b", id_pc_plus4, 32'h0000_0008);
    chk("t2_rel_inst_b", id_inst, 32'hA5A5_0004);
    wait_valid("t2_wait_c", 20);
    chk("t2_rel_pc4_c", id_pc_plus4, 32'h0000_000C);
    chk("t2_rel_inst_c", id_inst, 32'hA5A5_0008);

    // Memory not ready for 3 cycles.
    restart(1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_req", {31'b0, imem_req}, 32'd1);
      chk("t3_addr", imem_addr, 32'h0);
      chk("t3_valid", {31'b0, id_valid}, 32'd0);
    end
    cyc_in();
    imem_ready = 1'b1;
    wait_valid("t3_wait", 20);
    chk("t3_pc4", id_pc_plus4, 32'h0000_0004);

    // Redirect with two requests outstanding (3-cycle memory).
    restart(3, 1'b1, 1'b0);
    repeat (2) cyc_in();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    chk("t4_req_on_redir", {31'b0, imem_req}, 32'd0);
    cyc_in();
    redirect_valid = 1'b0;
    wait_req("t4_wait_req", 20);
    chk("t4_addr", imem_addr, 32'h0000_0100);
    wait_valid("t4_wait_valid", 20);
    chk("t4_pc4", id_pc_plus4, 32'h0000_0104);
    chk("t4_inst", id_inst, 32'hA5A5_0100);

    // Redirect coinciding with a response and a pop.
    restart(1, 1'b1, 1'b0);
    repeat (2) cyc_in();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    @(negedge clk);
    chk("t5_pre_valid", {31'b0, id_valid}, 32'd1);
    chk("t5_pre_rvalid", {31'b0, imem_rvalid}, 32'd1);
    cyc_in();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5_post_valid", {31'b0, id_valid}, 32'd0);
    wait_valid("t5_wait", 20);
    chk("t5_pc4", id_pc_plus4, 32'h0000_0044);
    chk("t5_inst", id_inst, 32'hA5A5_0040);

    // PC wrap-around on the second instance (running since the last reset).
    repeat (10) cyc_in();
    chk("t6_nreq", {31'b0, q_addr2.size() >= 3}, 32'd1);
    chk("t6_npres", {31'b0, q_pc2.size() >= 3}, 32'd1);
    if (q_addr2.size() >= 3 && q_pc2.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t6_addr", q_addr2[i], exp_a2[i]);
        chk("t6_pc4", q_pc2[i], exp_p2[i]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode stage. Owns the PC register and issues in-order requests to instruction memory.
- Buffers returned words in a small FIFO and presents {pc_plus4, inst} to decode with a valid/stall handshake.
- Handles control-flow redirects by flushing the buffer and discarding in-flight responses.

Parameters:
- ADDR_W, 32, instruction address width (matches InstAddrWidth).
- DATA_W, 32, instruction word width (matches InstDataWidth).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, fetch-buffer entries; also the cap on outstanding plus buffered instructions.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset. rst==0 at a clk edge resets all state.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address, always word-aligned.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid. Responses are in order and have no backpressure.
- imem_rdata  in  DATA_W  instruction word.
- redirect_valid  in  1  branch/jump taken; restart fetch.
- redirect_pc  in  ADDR_W  restart address; bits [1:0] are ignored and treated as 0.
- id_stall  in  1  decode cannot accept this cycle.
- id_valid  out  1  id_inst/id_pc_plus4 hold a real instruction.
- id_pc_plus4  out  ADDR_W  address of the presented instruction + 4.
- id_inst  out  DATA_W  presented instruction; 32'h0 (NOP) when id_valid==0.

Behaviour:
- Reset:
  - pc = resp_pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0.
  - imem_req = 0, id_valid = 0, id_inst = 0, id_pc_plus4 = 0.
- Registers:
  - pc: next address to request.
  - resp_pc: address of the next expected non-discarded response.
  - outstanding: accepted-but-unanswered request count, width clog2(DEPTH+1).
  - discard: responses still to drop, same width as outstanding.
- Request rule:
  - imem_req = rst & ~redirect_valid & (outstanding + fifo_count < DEPTH).
  - imem_addr = pc.
  - fire = imem_req & imem_ready. On fire: pc <= pc + 4 (mod 2^ADDR_W; 32'hFFFF_FFFC wraps to 0) and outstanding++.
- Response rule (imem_rvalid):
  - outstanding--.
  - If discard > 0: discard--, word dropped.
  - Else: push {resp_pc + 4, imem_rdata} into the FIFO and resp_pc += 4.
- Pop and latency:
  - pop = id_valid & ~id_stall.
  - id_* are driven combinationally from the FIFO head (DEPTH-entry register FIFO).
  - Minimum latency: a response arriving in cycle N is presented at decode in cycle N+1.
- Overflow: impossible by construction because of the request cap. A push into a full FIFO is an assertion failure.
- Push and pop together: both occur; count is unchanged.
- Redirect (redirect_valid==1), all effective at the clock edge:
  - FIFO cleared; pop is ignored.
  - pc <= resp_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - No request is issued this cycle.
  - discard <= outstanding after this cycle's response (a response arriving the same cycle is dropped).
  - Next cycle: id_valid = 0 and fetch restarts at the target.
- Delay slot: redirect flushes everything, including the head. Upstream control asserts redirect only once the delay-slot instruction has been consumed.
- id_stall with an empty FIFO has no effect.
- Reset mid-operation: all state returns to reset values regardless of in-flight traffic. Responses to pre-reset requests must not arrive after reset; this is a system-level requirement on the memory.

Decomposition:
- Shared package holds:
  - InstAddrWidth, InstDataWidth.
  - NOP encoding 32'h0.
  - Default RESET_PC.
  - fetch entry struct/width {pc_plus4, inst} = ADDR_W + DATA_W.
- One sub-module: fetch_fifo.
  - Parameterised DEPTH/WIDTH; push, pop, clear, count, head.
  - Synchronous active-low reset; clear has priority over push/pop.
- The top level holds pc, resp_pc, and the outstanding/discard counters.

Test Plan:
- Reset release, imem_ready=1, 1-cycle memory returning addr^32'hA5A5_0000, no stall -> requests at 0,4,8,…; decode sees (pc_plus4=4, inst=32'hA5A5_0000), then (8, …4) consecutively.
- Hold id_stall=1 for 5 cycles -> at most 2 outstanding+buffered; imem_req drops; head stays (4, 32'hA5A5_0000); no word lost after release.
- imem_ready=0 for 3 cycles -> imem_addr held at 0, pc unchanged, id_valid=0.
- Two requests outstanding when redirect_pc=32'h0000_0103 is asserted -> both responses dropped; next request addr 32'h100; next presented pc_plus4 32'h104.
- Redirect in the same cycle as a response and a pop -> response dropped, FIFO empty, id_valid=0 the next cycle.
- RESET_PC=32'hFFFF_FFF8 -> request addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; presented id_pc_plus4 FFFF_FFFC, 0000_0000, 0000_0004.
